// File: rtl/output_buffer.sv
// output_buffer: AXI4-Stream register slice with fully registered valid/data/ready paths
//
// Ports:
//   aclk, aresetn        clock (rising edge) and synchronous active-low reset
//   in_data, in_last     upstream payload and packet end marker
//   in_valid, in_ready   upstream handshake; in_ready decodes the state register only
//   out_data, out_last   payload taken straight from the main register
//   out_valid, out_ready downstream handshake; out_valid decodes the state register only
//   level                words held: 0, 1 or 2
//
// The main slot always feeds the outputs. The skid slot catches the one word
// that can arrive in the same cycle the downstream stalls, because in_ready
// only reflects the state at the start of that cycle.
module output_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            level
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state;
    logic [DATA_WIDTH-1:0] skid_data;
    logic skid_last;
    logic in_acc, out_acc;
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign level     = state;
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;
    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= EMPTY;
        else
            case (state)
                EMPTY:   state <= in_acc ? ONE : EMPTY;
                ONE:     state <= (in_acc & !out_acc) ? FULL : (!in_acc & out_acc) ? EMPTY : ONE;
                FULL:    state <= out_acc ? ONE : FULL;
                default: state <= EMPTY;
            endcase
    end
    // A new word goes straight to main when main is empty or being drained;
    // it parks in skid only when main is occupied and stalled.
    always_ff @(posedge aclk) begin
        if (in_acc & (!out_valid | out_ready))
            {out_data, out_last} <= {in_data, in_last};
        else if ((state == FULL) & out_acc)
            {out_data, out_last} <= {skid_data, skid_last};
        if (in_acc & out_valid & !out_ready)
            {skid_data, skid_last} <= {in_data, in_last};
    end
endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer: scoreboard bench for output_buffer
module tb_output_buffer;
    localparam int W = 32;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   level;
    int n_cmp = 0;
    int n_fail = 0;
    int n_rx = 0;
    logic [W:0] sb[$];
    logic [W:0] exp_w;

    output_buffer #(.DATA_WIDTH(W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
    );

    always #5 aclk = ~aclk;

    // Inputs change just after rising edges, so at the falling edge every
    // handshake signal holds the value the next rising edge will act on.
    always @(negedge aclk) begin
        if (!aresetn)
            sb.delete();
        else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                n_rx++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow got %0h/%0b expected nothing", out_data, out_last);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_last, out_data} !== exp_w) begin
                        n_fail++;
                        $display("FAIL scoreboard_word got last=%0b data=%0h expected last=%0b data=%0h",
                                 out_last, out_data, exp_w[W], exp_w[W-1:0]);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back({in_last, in_data});
        end
    end

    task automatic test_reset();
        aresetn = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h99;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got v=%0b r=%0b lvl=%0d expected v=0 r=1 lvl=0",
                         i, out_valid, in_ready, level);
            end
        end
        aresetn = 1'b1;
        in_data = 32'h77;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h77 || level !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_first_word got v=%0b d=%0h lvl=%0d expected v=1 d=77 lvl=1",
                     out_valid, out_data, level);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_data = W'(i);
            @(posedge aclk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== W'(i) || level !== 2'd1 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_word%0d got v=%0b d=%0h lvl=%0d r=%0b expected v=1 d=%0h lvl=1 r=1",
                         i, out_valid, out_data, level, in_ready, i);
            end
        end
        in_valid = 1'b0;
        @(posedge aclk); #1;
        n_cmp++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain got lvl=%0d v=%0b expected lvl=0 v=0", level, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA;
        @(posedge aclk); #1;
        in_data = 32'hB;
        @(posedge aclk); #1;
        in_data = 32'hC;
        n_cmp++;
        if (level !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full got lvl=%0d r=%0b expected lvl=2 r=0", level, in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 32'hA || level !== 2'd2 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_stable cyc=%0d got v=%0b d=%0h lvl=%0d r=%0b expected v=1 d=a lvl=2 r=0",
                         i, out_valid, out_data, level, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge aclk); #1;
        n_cmp++;
        if (out_data !== 32'hB || level !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_b got d=%0h lvl=%0d r=%0b expected d=b lvl=1 r=1", out_data, level, in_ready);
        end
        @(posedge aclk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_data !== 32'hC || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL release_c got d=%0h v=%0b expected d=c v=1", out_data, out_valid);
        end
        @(posedge aclk); #1;
        n_cmp++;
        if (level !== 2'd0) begin
            n_fail++;
            $display("FAIL release_empty got lvl=%0d expected 0", level);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        logic pend;
        n_rx = 0;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data = W'(sent);
                in_last = (sent % 7) == 6;
            end
            out_ready = $urandom_range(0, 3) != 0;
            pend = in_valid && in_ready;
            @(posedge aclk); #1;
            cyc++;
            if (pend) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && level != 2'd0; i++) begin
            @(posedge aclk); #1;
        end
        @(negedge aclk); #1;
        n_cmp++;
        if (sent != 10000 || n_rx != 10000 || sb.size() != 0 || level !== 2'd0) begin
            n_fail++;
            $display("FAIL random_totals got sent=%0d rx=%0d left=%0d lvl=%0d expected 10000/10000/0/0",
                     sent, n_rx, sb.size(), level);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h11;
        @(posedge aclk); #1;
        in_data = 32'h22;
        @(posedge aclk); #1;
        n_cmp++;
        if (level !== 2'd2) begin
            n_fail++;
            $display("FAIL midreset_fill got lvl=%0d expected 2", level);
        end
        aresetn = 1'b0;
        in_valid = 1'b0;
        @(posedge aclk); #1;
        n_cmp++;
        if (level !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_clear got lvl=%0d v=%0b r=%0b expected lvl=0 v=0 r=1",
                     level, out_valid, in_ready);
        end
        aresetn = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h55;
        out_ready = 1'b1;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h55 || level !== 2'd1) begin
            n_fail++;
            $display("FAIL midreset_first got v=%0b d=%0h lvl=%0d expected v=1 d=55 lvl=1",
                     out_valid, out_data, level);
        end
        @(posedge aclk); #1;
        @(negedge aclk); #1;
        n_cmp++;
        if (level !== 2'd0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_drain got lvl=%0d left=%0d expected lvl=0 left=0", level, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
